align_scheduler: RTL and testbench

- Arbitrates two operand requesters for the single shared operand-alignment stage.
  - Requester 0 is the add/sub issue path.
  - Requester 1 is the compare/misc issue path.
- Computes the operand-exchange decision and the right-shift count from the exponents.
- Registers the winning request, with those controls, into one valid/ready pipeline slot that drives the aligner.

---
 rtl/align_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_align_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/align_scheduler.sv
// Two-requester round-robin front end for the shared operand aligner: computes the
// exchange/shift controls and registers the winning op. Optional stats via ALIGN_SCHED_STATS_EN.
module align_scheduler #(
  parameter int unsigned SAT_SHIFT = 31
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef ALIGN_SCHED_STATS_EN
  output logic [15:0] grant_count_0,
  output logic [15:0] grant_count_1,
  output logic [15:0] stall_count,
`endif
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_addsub,
  input  logic [1:0]  req_sign_a,
  input  logic [1:0]  req_sign_b,
  input  logic [15:0] req_exp_a,
  input  logic [15:0] req_exp_b,
  input  logic [47:0] req_frac_a,
  input  logic [47:0] req_frac_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_src,
  output logic        exchange_operands,
  output logic [4:0]  align_shift_count,
  output logic        operand_sign_a,
  output logic        operand_sign_b,
  output logic [7:0]  unbiased_exponent_a,
  output logic [7:0]  unbiased_exponent_b,
  output logic [23:0] operand_fraction_a,
  output logic [23:0] operand_fraction_b
);

  localparam int unsigned EW = 8;
  localparam int unsigned FW = 24;
  localparam int unsigned SW = 5;
  localparam int unsigned DW = EW + 1;

  logic          out_valid_q, out_valid_d;
  logic          out_src_q, out_src_d;
  logic          exch_q, exch_d;
  logic [SW-1:0] shift_q, shift_d;
  logic          sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [EW-1:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
  logic [FW-1:0] frac_a_q, frac_a_d, frac_b_q, frac_b_d;
  logic          last_grant_q, last_grant_d;

  logic [1:0]    grant_c;
  logic          load_c, accept_c, sel_c;
  logic [EW-1:0] sel_exp_a_c, sel_exp_b_c;
  logic [FW-1:0] sel_frac_a_c, sel_frac_b_c;
  logic [DW-1:0] diff_c, mag_c;
  logic          exch_c;
  logic [SW-1:0] shift_c;

  // Round-robin grant from valids and last winner only
  always_comb begin
    grant_c = 2'b00;
    unique case (req_valid)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last_grant_q ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

  assign load_c    = !out_valid_q || out_ready;
  assign accept_c  = load_c && (grant_c != 2'b00);
  assign sel_c     = grant_c[1];
  assign req_ready = reset_n ? ({2{load_c}} & grant_c) : 2'b00;

  assign sel_exp_a_c  = sel_c ? req_exp_a[15:8]   : req_exp_a[7:0];
  assign sel_exp_b_c  = sel_c ? req_exp_b[15:8]   : req_exp_b[7:0];
  assign sel_frac_a_c = sel_c ? req_frac_a[47:24] : req_frac_a[23:0];
  assign sel_frac_b_c = sel_c ? req_frac_b[47:24] : req_frac_b[23:0];

  // Exponent difference in 9 bits so -255..255 never wraps
  always_comb begin
    diff_c  = {sel_exp_a_c[EW-1], sel_exp_a_c} - {sel_exp_b_c[EW-1], sel_exp_b_c};
    mag_c   = diff_c[DW-1] ? DW'(~diff_c + DW'(1)) : diff_c;
    exch_c  = 1'b0;
    shift_c = '0;
    if (req_addsub[sel_c]) begin
      exch_c  = diff_c[DW-1] || ((diff_c == '0) && (sel_frac_b_c > sel_frac_a_c));
      shift_c = (mag_c > DW'(SAT_SHIFT)) ? SW'(SAT_SHIFT) : mag_c[SW-1:0];
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_src_d    = out_src_q;
    exch_d       = exch_q;
    shift_d      = shift_q;
    sign_a_d     = sign_a_q;
    sign_b_d     = sign_b_q;
    exp_a_d      = exp_a_q;
    exp_b_d      = exp_b_q;
    frac_a_d     = frac_a_q;
    frac_b_d     = frac_b_q;
    last_grant_d = last_grant_q;
    if (load_c) begin
      out_valid_d = accept_c;
      if (accept_c) begin
        out_src_d    = sel_c;
        exch_d       = exch_c;
        shift_d      = shift_c;
        sign_a_d     = req_sign_a[sel_c];
        sign_b_d     = req_sign_b[sel_c];
        exp_a_d      = sel_exp_a_c;
        exp_b_d      = sel_exp_b_c;
        frac_a_d     = sel_frac_a_c;
        frac_b_d     = sel_frac_b_c;
        last_grant_d = sel_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_src_q    <= 1'b0;
      exch_q       <= 1'b0;
      shift_q      <= '0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      exp_a_q      <= '0;
      exp_b_q      <= '0;
      frac_a_q     <= '0;
      frac_b_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_src_q    <= out_src_d;
      exch_q       <= exch_d;
      shift_q      <= shift_d;
      sign_a_q     <= sign_a_d;
      sign_b_q     <= sign_b_d;
      exp_a_q      <= exp_a_d;
      exp_b_q      <= exp_b_d;
      frac_a_q     <= frac_a_d;
      frac_b_q     <= frac_b_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid           = out_valid_q;
  assign out_src             = out_src_q;
  assign exchange_operands   = exch_q;
  assign align_shift_count   = shift_q;
  assign operand_sign_a      = sign_a_q;
  assign operand_sign_b      = sign_b_q;
  assign unbiased_exponent_a = exp_a_q;
  assign unbiased_exponent_b = exp_b_q;
  assign operand_fraction_a  = frac_a_q;
  assign operand_fraction_b  = frac_b_q;

`ifdef ALIGN_SCHED_STATS_EN
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0] gcnt0_q, gcnt0_d, gcnt1_q, gcnt1_d, stall_q, stall_d;

  // Saturating event counters
  always_comb begin
    gcnt0_d = gcnt0_q;
    gcnt1_d = gcnt1_q;
    stall_d = stall_q;
    if (accept_c && !sel_c && (gcnt0_q != CMAX)) gcnt0_d = gcnt0_q + CW'(1);
    if (accept_c &&  sel_c && (gcnt1_q != CMAX)) gcnt1_d = gcnt1_q + CW'(1);
    if (out_valid_q && !out_ready && (stall_q != CMAX)) stall_d = stall_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      stall_q <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      stall_q <= stall_d;
    end
  end

  assign grant_count_0 = gcnt0_q;
  assign grant_count_1 = gcnt1_q;
  assign stall_count   = stall_q;
`endif

endmodule

// File: tb/tb_align_scheduler.sv
// Scoreboard bench for align_scheduler: directed vectors push expected ops, a negedge monitor
// pops and compares on every output handshake.
module tb_align_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_addsub, req_sign_a, req_sign_b;
  logic [15:0] req_exp_a, req_exp_b;
  logic [47:0] req_frac_a, req_frac_b;
  logic        out_valid, out_ready, out_src, exchange_operands;
  logic [4:0]  align_shift_count;
  logic        operand_sign_a, operand_sign_b;
  logic [7:0]  unbiased_exponent_a, unbiased_exponent_b;
  logic [23:0] operand_fraction_a, operand_fraction_b;
`ifdef ALIGN_SCHED_STATS_EN
  logic [15:0] grant_count_0, grant_count_1, stall_count;
  logic [15:0] stall_base;
`endif

  always #5 clk = ~clk;

  align_scheduler #(.SAT_SHIFT(31)) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef ALIGN_SCHED_STATS_EN
    .grant_count_0(grant_count_0), .grant_count_1(grant_count_1), .stall_count(stall_count),
`endif
    .req_valid(req_valid), .req_ready(req_ready), .req_addsub(req_addsub),
    .req_sign_a(req_sign_a), .req_sign_b(req_sign_b),
    .req_exp_a(req_exp_a), .req_exp_b(req_exp_b),
    .req_frac_a(req_frac_a), .req_frac_b(req_frac_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .exchange_operands(exchange_operands), .align_shift_count(align_shift_count),
    .operand_sign_a(operand_sign_a), .operand_sign_b(operand_sign_b),
    .unbiased_exponent_a(unbiased_exponent_a), .unbiased_exponent_b(unbiased_exponent_b),
    .operand_fraction_a(operand_fraction_a), .operand_fraction_b(operand_fraction_b)
  );

  typedef struct packed {
    logic        addsub;
    logic        sa;
    logic        sb;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] fa;
    logic [23:0] fb;
    logic        exch;
    logic [4:0]  sh;
  } vec_t;

  typedef struct packed {
    logic src;
    vec_t v;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  vec_t        cur[2];
  int          errors = 0;
  int          checks = 0;
  logic [72:0] dut_obs;

  assign dut_obs = {out_src, exchange_operands, align_shift_count, operand_sign_a, operand_sign_b,
                    unbiased_exponent_a, unbiased_exponent_b, operand_fraction_a, operand_fraction_b};

  function automatic vec_t mk(logic as, logic sa, logic sb, logic [7:0] ea, logic [7:0] eb,
                              logic [23:0] fa, logic [23:0] fb, logic ex, logic [4:0] sh);
    vec_t v;
    v.addsub = as; v.sa = sa; v.sb = sb; v.ea = ea; v.eb = eb;
    v.fa = fa; v.fb = fb; v.exch = ex; v.sh = sh;
    return v;
  endfunction

  function automatic logic [72:0] obs_of(logic src, vec_t v);
    return {src, v.exch, v.sh, v.sa, v.sb, v.ea, v.eb, v.fa, v.fb};
  endfunction

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_vec(input int i, input vec_t v);
    cur[i] = v;
    req_addsub[i] = v.addsub;
    req_sign_a[i] = v.sa;
    req_sign_b[i] = v.sb;
    req_exp_a[i*8 +: 8]   = v.ea;
    req_exp_b[i*8 +: 8]   = v.eb;
    req_frac_a[i*24 +: 24] = v.fa;
    req_frac_b[i*24 +: 24] = v.fb;
  endtask

  // One cycle: drive valids, check the expected grant, push what should be accepted
  task automatic step(input logic [1:0] v, input logic [1:0] exp_rdy);
    exp_t e;
    req_valid = v;
    @(negedge clk);
    check("req_ready", 73'(req_ready), 73'(exp_rdy));
    for (int i = 0; i < 2; i++) begin
      if (v[i] && exp_rdy[i]) begin
        e.src = i[0];
        e.v   = cur[i];
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", dut_obs);
      end else begin
        mon_e = sb_q.pop_front();
        check("scoreboard", dut_obs, obs_of(mon_e.src, mon_e.v));
      end
    end
  end

  vec_t v_align, v_pass, v_sat, v_tie, v_eq, v_pos, v_big, v_pass2, v_rr0, v_rr1, v_st;

  initial begin
    v_align = mk(1, 0, 1, 8'd3,   8'd10,  24'h900000, 24'hA00000, 1, 5'd7);
    v_pass  = mk(0, 1, 0, 8'd0,   8'd20,  24'h812345, 24'hFFFFFF, 0, 5'd0);
    v_sat   = mk(1, 0, 0, 8'h9C,  8'h64,  24'hC00000, 24'h800000, 1, 5'd31);
    v_tie   = mk(1, 1, 1, 8'd5,   8'd5,   24'h800000, 24'hC00000, 1, 5'd0);
    v_eq    = mk(1, 0, 1, 8'hF0,  8'hF0,  24'hA5A5A5, 24'hA5A5A5, 0, 5'd0);
    v_pos   = mk(1, 1, 0, 8'd20,  8'hF6,  24'h800001, 24'hFFFFFF, 0, 5'd30);
    v_big   = mk(1, 0, 0, 8'h7F,  8'h80,  24'h8000AA, 24'h800055, 0, 5'd31);
    v_pass2 = mk(0, 1, 1, 8'h80,  8'h7F,  24'h111111, 24'h222222, 0, 5'd0);
    v_rr0   = mk(1, 0, 0, 8'd1,   8'd1,   24'h400000, 24'h400000, 0, 5'd0);
    v_rr1   = mk(1, 1, 0, 8'hFF,  8'd2,   24'h123456, 24'h654321, 1, 5'd3);
    v_st    = mk(1, 0, 1, 8'd10,  8'd9,   24'h800000, 24'h800000, 0, 5'd1);

    reset_n = 1'b0;
    out_ready = 1'b1;
    req_valid = 2'b11;
    req_addsub = '0; req_sign_a = '0; req_sign_b = '0;
    req_exp_a = '0; req_exp_b = '0; req_frac_a = '0; req_frac_b = '0;
    load_vec(0, v_align);
    load_vec(1, v_pass);
    @(posedge clk);
    #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("reset_out_valid", 73'(out_valid), 73'(0));
      check("reset_req_ready", 73'(req_ready), 73'(0));
      @(posedge clk);
      #1;
    end
    check("reset_outputs", dut_obs, 73'(0));

    reset_n = 1'b1;
    step(2'b11, 2'b01);
    step(2'b10, 2'b10);

    load_vec(0, v_sat);   step(2'b01, 2'b01);
    load_vec(0, v_tie);   step(2'b01, 2'b01);
    load_vec(0, v_eq);    step(2'b01, 2'b01);
    load_vec(0, v_pos);   step(2'b01, 2'b01);
    load_vec(0, v_big);   step(2'b01, 2'b01);
    load_vec(1, v_pass2); step(2'b10, 2'b10);

    load_vec(0, v_rr0);
    load_vec(1, v_rr1);
    step(2'b11, 2'b01);
    step(2'b11, 2'b10);
    step(2'b11, 2'b01);
    step(2'b11, 2'b10);

    // Slot now holds v_rr1 from requester 1; stall it
    load_vec(0, v_st);
    out_ready = 1'b0;
`ifdef ALIGN_SCHED_STATS_EN
    stall_base = stall_count;
`endif
    req_valid = 2'b01;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_req_ready", 73'(req_ready), 73'(0));
      check("stall_out_valid", 73'(out_valid), 73'(1));
      check("stall_hold", dut_obs, obs_of(1'b1, v_rr1));
      @(posedge clk);
      #1;
    end
`ifdef ALIGN_SCHED_STATS_EN
    check("stall_count_delta", 73'(16'(stall_count - stall_base)), 73'(3));
`endif
    out_ready = 1'b1;
    step(2'b01, 2'b01);
    step(2'b00, 2'b00);
    step(2'b00, 2'b00);
    check("drain_out_valid", 73'(out_valid), 73'(0));
    check("scoreboard_empty", 73'(sb_q.size()), 73'(0));
`ifdef ALIGN_SCHED_STATS_EN
    check("grant_count_0", 73'(grant_count_0), 73'(9));
    check("grant_count_1", 73'(grant_count_1), 73'(4));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
